// File: rtl/movwide_const_encoder_if.sv
// Request/instruction handshake bundle for the MOVZ/MOVK constant encoder.
// Requester drives the constant; the encoder streams 32-bit instructions back.
interface movwide_const_encoder_if;
  logic        InValid;
  logic        InReady;
  logic [63:0] ImmIn;
  logic [4:0]  RdIn;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] InstrOut;
  logic        OutLast;
  logic [1:0]  SeqIdx;

  modport master (
    output InValid, ImmIn, RdIn, OutReady,
    input  InReady, OutValid, InstrOut, OutLast, SeqIdx
  );

  modport slave (
    input  InValid, ImmIn, RdIn, OutReady,
    output InReady, OutValid, InstrOut, OutLast, SeqIdx
  );
endinterface

// File: rtl/movwide_const_encoder.sv
// Turns a 64-bit constant into the shortest MOVZ + MOVK sequence.
// One registered instruction per output handshake, ascending halfword order.
module movwide_const_encoder #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input logic                     CLK,
  input logic                     Reset_L,
  movwide_const_encoder_if.slave  bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] val;
  logic [4:0]  rd;
  logic [3:0]  rem;
  logic [31:0] instr;
  logic        last;
  logic [1:0]  idx;

  logic [3:0]  m_in;
  logic [1:0]  first_hw;
  logic [3:0]  first_rem;
  logic [1:0]  next_hw;
  logic [3:0]  next_rem;
  logic        accept;
  logic        adv;

  function automatic logic [1:0] low_idx(
    input logic [3:0] m
  );
    logic [1:0] r;
    r = 2'd0;
    if (m[0])      r = 2'd0;
    else if (m[1]) r = 2'd1;
    else if (m[2]) r = 2'd2;
    else if (m[3]) r = 2'd3;
    return r;
  endfunction

  function automatic logic [3:0] clr_bit(
    input logic [3:0] m,
    input logic [1:0] hw
  );
    return m & ~(4'b0001 << hw);
  endfunction

  // bit 29 set selects MOVK (F28...), clear selects MOVZ (D28...)
  function automatic logic [31:0] enc(
    input logic        keep,
    input logic [1:0]  hw,
    input logic [15:0] imm,
    input logic [4:0]  r
  );
    return {keep ? 9'h1E5 : 9'h1A5, hw, imm, r};
  endfunction

  always_comb begin
    m_in = 4'b0000;
    for (int i = 0; i < 4; i++)
      m_in[i] = |bus.ImmIn[16*i +: 16];
    if (!SKIP_ZERO)
      m_in = 4'b1111;
  end

  always_comb begin
    first_hw  = low_idx(m_in);
    first_rem = clr_bit(m_in, first_hw);
    next_hw   = low_idx(rem);
    next_rem  = clr_bit(rem, next_hw);
  end

  assign accept = (state == IDLE) && bus.InValid;
  assign adv    = (state == EMIT) && bus.OutReady;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = EMIT;
      EMIT: if (adv && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.InReady  = (state == IDLE);
    bus.OutValid = (state == EMIT);
    bus.InstrOut = instr;
    bus.OutLast  = last;
    bus.SeqIdx   = idx;
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      val   <= '0;
      rd    <= '0;
      rem   <= '0;
      instr <= '0;
      last  <= 1'b0;
      idx   <= '0;
    end else if (accept) begin
      val   <= bus.ImmIn;
      rd    <= bus.RdIn;
      rem   <= first_rem;
      instr <= enc(1'b0, first_hw,
                   bus.ImmIn[{first_hw, 4'b0} +: 16],
                   bus.RdIn);
      last  <= (first_rem == 4'b0000);
      idx   <= 2'd0;
    end else if (adv && !last) begin
      rem   <= next_rem;
      instr <= enc(1'b1, next_hw,
                   val[{next_hw, 4'b0} +: 16], rd);
      last  <= (next_rem == 4'b0000);
      idx   <= idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_movwide_const_encoder.sv
// Scoreboard bench for the constant encoder, both SKIP_ZERO settings.
// Expected instructions are queued on request and popped on output.
module tb_movwide_const_encoder;

  logic CLK = 1'b0;
  logic Reset_L = 1'b0;
  always #5 CLK = ~CLK;

  movwide_const_encoder_if ba ();
  movwide_const_encoder_if bb ();

  movwide_const_encoder #(.SKIP_ZERO(1'b1)) dut_a (
    .CLK(CLK), .Reset_L(Reset_L), .bus(ba.slave)
  );
  movwide_const_encoder #(.SKIP_ZERO(1'b0)) dut_b (
    .CLK(CLK), .Reset_L(Reset_L), .bus(bb.slave)
  );

  int total = 0;
  int bad = 0;
  logic [38:0] qa[$];
  logic [38:0] qb[$];
  bit bp_a = 1'b0;
  logic [34:0] held_a;
  bit hv_a = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [63:0] imm,
                                input logic [4:0] rd,
                                input bit skip,
                                input bit sel);
    logic [3:0]  m;
    logic [31:0] ins;
    logic [38:0] e;
    int n;
    n = 0;
    for (int i = 0; i < 4; i++)
      m[i] = skip ? (imm[16*i +: 16] != 16'h0) : 1'b1;
    if (m == 4'b0000) m = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        ins = (n == 0) ? 32'hD280_0000 : 32'hF280_0000;
        ins = ins | (32'(i) << 21)
                  | (32'(imm[16*i +: 16]) << 5)
                  | 32'(rd);
        e = {ins, 4'b0, (m >> (i + 1)) == 4'b0, 2'(n)};
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
        n++;
      end
    end
  endfunction

  always @(negedge CLK) begin
    logic [38:0] e;
    if (ba.OutValid && hv_a)
      chk("a_hold", {ba.InstrOut, ba.OutLast, ba.SeqIdx}, held_a);
    hv_a   <= ba.OutValid && !ba.OutReady;
    held_a <= {ba.InstrOut, ba.OutLast, ba.SeqIdx};
    if (ba.OutValid && ba.OutReady) begin
      if (qa.size() == 0) chk("a_extra", qa.size(), 1);
      else begin
        e = qa.pop_front();
        chk("a_instr", ba.InstrOut, e[38:7]);
        chk("a_last", ba.OutLast, e[2]);
        chk("a_idx", ba.SeqIdx, e[1:0]);
      end
    end
  end

  always @(negedge CLK) begin
    logic [38:0] e;
    if (bb.OutValid && bb.OutReady) begin
      if (qb.size() == 0) chk("b_extra", qb.size(), 1);
      else begin
        e = qb.pop_front();
        chk("b_instr", bb.InstrOut, e[38:7]);
        chk("b_last", bb.OutLast, e[2]);
        chk("b_idx", bb.SeqIdx, e[1:0]);
      end
    end
  end

  always @(posedge CLK)
    if (bp_a) begin
      #1;
      ba.OutReady = 1'($urandom_range(0, 1));
    end

  task automatic send_a(input logic [63:0] imm, input logic [4:0] rd);
    int n;
    n = 0;
    @(posedge CLK); #1;
    ba.InValid = 1'b1;
    ba.ImmIn = imm;
    ba.RdIn = rd;
    model(imm, rd, 1'b1, 1'b0);
    while (!ba.InReady && n < 200) begin
      @(posedge CLK); #1; n++;
    end
    if (n >= 200) chk("a_accept_to", 64'(n), 0);
    @(posedge CLK); #1;
    ba.InValid = 1'b0;
    ba.ImmIn = 64'hDEAD_BEEF_5A5A_A5A5;
    ba.RdIn = 5'd30;
  endtask

  task automatic drain_a;
    int n;
    n = 0;
    while (qa.size() != 0 && n < 400) begin
      @(posedge CLK); n++;
    end
    chk("a_drain", qa.size(), 0);
  endtask

  initial begin
    logic [63:0] r;
    int n;
    ba.InValid = 1'b0; ba.ImmIn = '0; ba.RdIn = '0;
    ba.OutReady = 1'b1;
    bb.InValid = 1'b0; bb.ImmIn = '0; bb.RdIn = '0;
    bb.OutReady = 1'b1;
    #22;
    chk("rst_inready", ba.InReady, 1);
    chk("rst_outvalid", ba.OutValid, 0);
    chk("rst_instr", ba.InstrOut, 0);
    chk("rst_last", ba.OutLast, 0);
    chk("rst_idx", ba.SeqIdx, 0);
    Reset_L = 1'b1;

    send_a(64'h0000_0000_0000_1234, 5'd3);
    chk("lat_valid", ba.OutValid, 1);
    chk("lat_instr", ba.InstrOut, 32'hD282_4683);
    chk("lat_last", ba.OutLast, 1);
    chk("lat_idx", ba.SeqIdx, 0);
    drain_a;
    #1;
    chk("ret_inready", ba.InReady, 1);
    chk("ret_outvalid", ba.OutValid, 0);

    send_a(64'h0, 5'd0);
    chk("zero_instr", ba.InstrOut, 32'hD280_0000);
    drain_a;
    send_a(64'h1234_0000_0000_ABCD, 5'd9);
    chk("two_first", ba.InstrOut, 32'hD295_79A9);
    drain_a;
    send_a(64'hFFFF_0000_0000_0000, 5'd1);
    chk("top_instr", ba.InstrOut, 32'hD2FF_FFE1);
    drain_a;
    send_a(64'h0000_0000_FFFF_0000, 5'd31);
    drain_a;

    bp_a = 1'b1;
    send_a(64'h0001_0000_0002_0003, 5'd17);
    drain_a;
    for (int k = 0; k < 6; k++) begin
      r = {$urandom, $urandom};
      for (int h = 0; h < 4; h++)
        if ($urandom_range(0, 1) == 1) r[16*h +: 16] = 16'h0;
      send_a(r, 5'($urandom_range(0, 31)));
      drain_a;
    end
    bp_a = 1'b0;
    @(posedge CLK); #1;
    ba.OutReady = 1'b1;

    @(posedge CLK); #1;
    bb.InValid = 1'b1; bb.ImmIn = 64'h1; bb.RdIn = 5'd5;
    model(64'h1, 5'd5, 1'b0, 1'b1);
    @(posedge CLK); #1;
    bb.InValid = 1'b0;
    n = 0;
    while (qb.size() != 0 && n < 100) begin
      @(posedge CLK); n++;
    end
    chk("b_drain", qb.size(), 0);

    send_a(64'h0005_0000_0006_0007, 5'd4);
    @(posedge CLK); #1;
    ba.OutReady = 1'b0;
    chk("mid_idx", ba.SeqIdx, 1);
    @(negedge CLK);
    #2 Reset_L = 1'b0;
    #1;
    chk("arst_outvalid", ba.OutValid, 0);
    chk("arst_inready", ba.InReady, 1);
    chk("arst_idx", ba.SeqIdx, 0);
    chk("arst_instr", ba.InstrOut, 0);
    qa.delete();
    #1 Reset_L = 1'b1;
    ba.OutReady = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("post_idle", ba.OutValid, 0);
    send_a(64'h8000_0000_0009_0000, 5'd12);
    chk("post_idx", ba.SeqIdx, 0);
    drain_a;

    repeat (2) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
